// File: rtl/pcie_dll_pkg.sv
// Shared data-link types and helpers for Ack/Nak DLLP generation.
package pcie_dll_pkg;

    typedef logic [11:0] seq_t;

    typedef enum logic [1:0] {
        GOOD = 2'b00,
        DUP  = 2'b01,
        BAD  = 2'b10,
        RSVD = 2'b11
    } rx_status_e;

    localparam logic [7:0] DLLP_ACK = 8'h00;
    localparam logic [7:0] DLLP_NAK = 8'h10;

    function automatic logic [31:0] build_acknak(input logic [7:0] dllp_type, input seq_t seq);
        return {dllp_type, 8'h00, 4'h0, seq};
    endfunction

endpackage

// File: rtl/ack_nak_dllp_gen.sv
// Ack/Nak DLLP generator: tracks the last good RX sequence number, coalesces Acks
// by count and age, and issues at most one Nak until a good TLP recovers the link.
//
//  state | meaning
//  IDLE  | no DLLP offered; pending Nak/Ack requests evaluated each cycle
//  SEND  | dllp_out offered with dllp_valid=1 until dllp_ready
module ack_nak_dllp_gen
    import pcie_dll_pkg::*;
#(
    parameter int ACK_COALESCE = 4,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_tlp_valid,
    input  logic [11:0] rx_tlp_seq,
    input  logic [1:0]  rx_tlp_status,
    input  logic        link_up,
    output logic [31:0] dllp_out,
    output logic        dllp_valid,
    input  logic        dllp_ready,
    output logic        ack_pending,
    output logic        nak_scheduled
);

    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [3:0] COALESCE   = 4'(ACK_COALESCE);
    localparam logic [3:0] CNT_MAX    = 4'hF;

    state_e     state;
    seq_t       ack_seq;
    logic [3:0] cnt;
    logic [7:0] timer;
    logic       nak_req;
    logic       dup_req;

    logic       rx_live;
    logic       ev_good;
    logic       ev_dup;
    logic       ev_bad;
    logic       in_idle;
    logic       launch_nak;
    logic       launch_ack;

    // Launch decisions look only at registered requests, so a TLP arriving in
    // the launch cycle is folded into the next DLLP rather than this one.
    // The one exception: a good TLP cancels a Nak that has not gone out yet.
    always_comb begin
        rx_live    = rx_tlp_valid && link_up;
        ev_good    = rx_live && (rx_status_e'(rx_tlp_status) == GOOD);
        ev_dup     = rx_live && (rx_status_e'(rx_tlp_status) == DUP);
        ev_bad     = rx_live && rx_tlp_status[1];
        in_idle    = (state == IDLE);
        launch_nak = in_idle && nak_req && !ev_good;
        launch_ack = in_idle && !launch_nak &&
                     (dup_req || (cnt >= COALESCE) || (timer == TIMER_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset || !link_up) begin
            state         <= IDLE;
            dllp_out      <= '0;
            dllp_valid    <= 1'b0;
            ack_pending   <= 1'b0;
            nak_scheduled <= 1'b0;
            ack_seq       <= 12'hFFF;
            cnt           <= '0;
            timer         <= '0;
            nak_req       <= 1'b0;
            dup_req       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch_nak || launch_ack) begin
                        state      <= SEND;
                        dllp_valid <= 1'b1;
                        dllp_out   <= build_acknak(launch_nak ? DLLP_NAK : DLLP_ACK, ack_seq);
                    end
                end
                SEND: begin
                    if (dllp_ready) begin
                        state      <= IDLE;
                        dllp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Timer holds at its terminal value so a Nak taking priority cannot
            // let it wrap past the Ack deadline.
            if (launch_ack) begin
                timer       <= '0;
                cnt         <= '0;
                ack_pending <= 1'b0;
                dup_req     <= 1'b0;
            end else if (in_idle && ack_pending && (timer != TIMER_LAST)) begin
                timer <= timer + 8'd1;
            end

            if (launch_nak)
                nak_req <= 1'b0;

            if (ev_good) begin
                ack_seq       <= rx_tlp_seq;
                ack_pending   <= 1'b1;
                cnt           <= launch_ack ? 4'd1 : ((cnt == CNT_MAX) ? cnt : cnt + 4'd1);
                nak_scheduled <= 1'b0;
                nak_req       <= 1'b0;
            end

            if (ev_dup)
                dup_req <= 1'b1;

            if (ev_bad && !nak_scheduled) begin
                nak_req       <= 1'b1;
                nak_scheduled <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ack_nak_dllp_gen.sv
// Directed scenarios plus randomized traffic for ack_nak_dllp_gen, checked every
// cycle against a rule-level reference model of the Ack/Nak protocol.
module tb_ack_nak_dllp_gen;

    localparam int COAL = 4;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_tlp_valid = 1'b0;
    logic [11:0] rx_tlp_seq = '0;
    logic [1:0]  rx_tlp_status = '0;
    logic        link_up = 1'b1;
    logic [31:0] dllp_out;
    logic        dllp_valid;
    logic        dllp_ready = 1'b1;
    logic        ack_pending;
    logic        nak_scheduled;

    ack_nak_dllp_gen #(.ACK_COALESCE(COAL), .ACK_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_tlp_valid  (rx_tlp_valid),
        .rx_tlp_seq    (rx_tlp_seq),
        .rx_tlp_status (rx_tlp_status),
        .link_up       (link_up),
        .dllp_out      (dllp_out),
        .dllp_valid    (dllp_valid),
        .dllp_ready    (dllp_ready),
        .ack_pending   (ack_pending),
        .nak_scheduled (nak_scheduled)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the link partner is owed, kept as plain variables.
    logic [11:0] m_seq = 12'hFFF;
    bit          m_pending, m_nak_sched, m_nak_owed, m_dup_owed, m_valid;
    int          m_cnt, m_age;
    logic [31:0] m_out;

    logic [31:0] dut_log[$];
    bit          prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit good, dup, bad, fire_nak, fire_ack, was_idle;
        if (reset || !link_up) begin
            m_seq = 12'hFFF; m_pending = 0; m_cnt = 0; m_age = 0;
            m_nak_owed = 0; m_dup_owed = 0; m_nak_sched = 0;
            m_valid = 0; m_out = '0;
            return;
        end
        good = rx_tlp_valid && (rx_tlp_status == 2'b00);
        dup  = rx_tlp_valid && (rx_tlp_status == 2'b01);
        bad  = rx_tlp_valid && rx_tlp_status[1];
        was_idle = !m_valid;
        fire_nak = 0;
        fire_ack = 0;
        if (!was_idle) begin
            if (dllp_ready) m_valid = 0;
        end else if (m_nak_owed && !good) begin
            fire_nak = 1;
        end else if (m_dup_owed || m_cnt >= COAL || m_age == TMO - 1) begin
            fire_ack = 1;
        end
        if (fire_nak || fire_ack) begin
            m_valid = 1;
            m_out = {(fire_nak ? 8'h10 : 8'h00), 12'h000, m_seq};
        end
        if (fire_ack) begin
            m_age = 0; m_cnt = 0; m_pending = 0; m_dup_owed = 0;
        end else if (was_idle && m_pending && m_age < TMO - 1) begin
            m_age++;
        end
        if (fire_nak) m_nak_owed = 0;
        if (good) begin
            m_seq = rx_tlp_seq; m_pending = 1;
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            m_nak_sched = 0; m_nak_owed = 0;
        end
        if (dup) m_dup_owed = 1;
        if (bad && !m_nak_sched) begin
            m_nak_owed = 1; m_nak_sched = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("dllp_valid", 32'(dllp_valid), 32'(m_valid));
        check("dllp_out", dllp_out, m_out);
        check("ack_pending", 32'(ack_pending), 32'(m_pending));
        check("nak_scheduled", 32'(nak_scheduled), 32'(m_nak_sched));
        if (dllp_valid && !prev_valid) dut_log.push_back(dllp_out);
        prev_valid = dllp_valid;
    endtask

    task automatic tlp(input logic [11:0] seq, input logic [1:0] status);
        rx_tlp_valid  = 1'b1;
        rx_tlp_seq    = seq;
        rx_tlp_status = status;
        step();
        rx_tlp_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        dut_log.delete();
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (dut_log.size() > i) ? dut_log[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic [11:0] next_seq;

        // Reset state
        do_reset();
        check("rst_valid", 32'(dllp_valid), 32'd0);
        check("rst_out", dllp_out, 32'd0);
        check("rst_pending", 32'(ack_pending), 32'd0);
        check("rst_nak", 32'(nak_scheduled), 32'd0);

        // T1: four good TLPs coalesce into one Ack of seq 3
        tlp(12'd0, 2'b00); tlp(12'd1, 2'b00); tlp(12'd2, 2'b00); tlp(12'd3, 2'b00);
        check("t1_no_early", dut_log.size(), 0);
        step();
        check("t1_count", dut_log.size(), 1);
        check("t1_ack3", log_at(0), 32'h0000_0003);
        check("t1_pending", 32'(ack_pending), 32'd0);
        idle(2);

        // T2: lone good TLP is acked only when the timer reaches its limit
        do_reset();
        tlp(12'd7, 2'b00);
        idle(TMO - 1);
        check("t2_not_early", dut_log.size(), 0);
        step();
        check("t2_count", dut_log.size(), 1);
        check("t2_ack7", log_at(0), 32'h0000_0007);
        idle(2);

        // T3: one Nak for a burst of bad TLPs, cleared by the next good one
        do_reset();
        tlp(12'd5, 2'b00);
        tlp(12'd0, 2'b10); tlp(12'd0, 2'b10); tlp(12'd0, 2'b11);
        idle(5);
        check("t3_count", dut_log.size(), 1);
        check("t3_nak5", log_at(0), 32'h1000_0005);
        check("t3_nak_sched", 32'(nak_scheduled), 32'd1);
        tlp(12'd6, 2'b00);
        check("t3_nak_clear", 32'(nak_scheduled), 32'd0);
        idle(TMO + 4);
        check("t3_no_2nd_nak", log_at(1), 32'h0000_0006);

        // T4: back-pressure holds dllp_out; carried-over goods acked afterwards
        do_reset();
        dllp_ready = 1'b0;
        tlp(12'd0, 2'b00); tlp(12'd1, 2'b00); tlp(12'd2, 2'b00); tlp(12'd3, 2'b00);
        step();
        tlp(12'd4, 2'b00); tlp(12'd5, 2'b00);
        idle(7);
        check("t4_hold_valid", 32'(dllp_valid), 32'd1);
        check("t4_hold_out", dllp_out, 32'h0000_0003);
        dllp_ready = 1'b1;
        step();
        check("t4_released", 32'(dllp_valid), 32'd0);
        dut_log.delete();
        for (int i = 0; i < 100 && dut_log.size() == 0; i++) step();
        check("t4_ack5_seen", dut_log.size(), 1);
        check("t4_ack5", log_at(0), 32'h0000_0005);
        idle(2);

        // T5: sequence wrap and duplicate-forced Ack
        do_reset();
        tlp(12'd4095, 2'b00); tlp(12'd0, 2'b00); tlp(12'd0, 2'b01);
        check("t5_no_early", dut_log.size(), 0);
        step();
        check("t5_ack0", log_at(0), 32'h0000_0000);
        idle(2);

        // T6: link drop while a DLLP is offered flushes everything
        do_reset();
        dllp_ready = 1'b0;
        tlp(12'h123, 2'b00); tlp(12'd0, 2'b01);
        step();
        check("t6_offered", 32'(dllp_valid), 32'd1);
        link_up = 1'b0;
        step();
        link_up = 1'b1;
        check("t6_dropped", 32'(dllp_valid), 32'd0);
        check("t6_pending", 32'(ack_pending), 32'd0);
        dllp_ready = 1'b1;
        dut_log.delete();
        tlp(12'd0, 2'b01);
        step();
        check("t6_ack_fff", log_at(0), 32'h0000_0FFF);

        // Reset mid-handshake
        dllp_ready = 1'b0;
        tlp(12'd0, 2'b01);
        step();
        reset = 1'b1;
        step();
        check("rst_mid_valid", 32'(dllp_valid), 32'd0);
        reset = 1'b0;
        dllp_ready = 1'b1;
        idle(2);

        // Randomized traffic against the model
        next_seq = 12'd0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            reset      = ($urandom_range(0, 499) == 0);
            link_up    = ($urandom_range(0, 199) != 0);
            dllp_ready = ($urandom_range(0, 9) < 7);
            rx_tlp_valid = ($urandom_range(0, 9) < 4);
            r = $urandom_range(0, 9);
            rx_tlp_status = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : 2'($urandom_range(2, 3));
            rx_tlp_seq = ($urandom_range(0, 19) == 0) ? 12'($urandom) : next_seq;
            if (rx_tlp_valid && rx_tlp_status == 2'b00) next_seq = rx_tlp_seq + 12'd1;
            step();
        end
        reset = 1'b0;
        link_up = 1'b1;
        rx_tlp_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
